// File: rtl/upc_scan_receiver_if.sv
// upc_scan_receiver_if: scanner line and decoded-item bus of the checkout scan front end.
//   scan_in     serial scanner line, idle high (driven by the scanner/master)
//   U, P, C, M  last accepted item code and mark bit
//   code_valid  1-cycle pulse when U,P,C,M are loaded
//   frame_err   1-cycle pulse when a frame is rejected
//   have_code   level, set once any frame has been accepted since reset
interface upc_scan_receiver_if;
    logic scan_in;
    logic U;
    logic P;
    logic C;
    logic M;
    logic code_valid;
    logic frame_err;
    logic have_code;
    modport master (output scan_in, input U, P, C, M, code_valid, frame_err, have_code);
    modport slave (input scan_in, output U, P, C, M, code_valid, frame_err, have_code);
endinterface

// File: rtl/upc_scan_receiver.sv
// upc_scan_receiver: samples 7-bit scanner frames, validates them and holds the last good U,P,C,M code.
//   clk    system clock, rising edge
//   reset  synchronous, active-high; aborts any frame in progress
//   bus    slave side of upc_scan_receiver_if (scan_in in; U,P,C,M, code_valid, frame_err, have_code out)
module upc_scan_receiver #(
    parameter int BIT_CYCLES = 4,
    parameter bit PARITY_ODD = 1'b1
) (
    input logic clk,
    input logic reset,
    upc_scan_receiver_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int CW = $clog2(BIT_CYCLES);
    state_t r_state, w_next;
    logic r_s1, r_s2, r_s_prev;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [1:0] r_idx, w_idx;
    logic [3:0] r_data, w_data;
    logic r_par, w_par;
    logic [3:0] r_upcm;
    logic r_valid, r_err, r_have;
    logic w_half, w_full, w_good, w_load, w_err;
    assign w_half = r_cnt == CW'(BIT_CYCLES / 2 - 1);
    assign w_full = r_cnt == CW'(BIT_CYCLES - 1);
    // r_data holds {U,P,C,M}; the stop sample is the live synchronized line
    assign w_good = r_s2 && ((^{r_data, r_par}) == PARITY_ODD)
                    && r_data[3:1] != 3'b010 && r_data[3:1] != 3'b111;
    always_comb begin
        w_next = r_state;
        w_cnt = r_cnt + 1'b1;
        w_idx = r_idx;
        w_data = r_data;
        w_par = r_par;
        w_load = 1'b0;
        w_err = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                // r_s_prev tracks the line in every state, so a line already low on return to IDLE is not an edge
                if (!r_s2 && r_s_prev) w_next = START;
            end
            START: if (w_half) begin
                w_cnt = '0;
                w_idx = '0;
                w_next = r_s2 ? IDLE : DATA;
            end
            DATA: if (w_full) begin
                w_cnt = '0;
                w_data = {r_data[2:0], r_s2};
                w_idx = r_idx + 2'd1;
                w_next = r_idx == 2'd3 ? PARITY : DATA;
            end
            PARITY: if (w_full) begin
                w_cnt = '0;
                w_par = r_s2;
                w_next = STOP;
            end
            STOP: if (w_full) begin
                w_next = IDLE;
                w_load = w_good;
                w_err = !w_good;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s_prev <= 1'b1;
            r_state <= IDLE;
            r_cnt <= '0;
            r_idx <= '0;
            r_data <= '0;
            r_par <= 1'b0;
            r_upcm <= '0;
            r_valid <= 1'b0;
            r_err <= 1'b0;
            r_have <= 1'b0;
        end else begin
            r_s1 <= bus.scan_in;
            r_s2 <= r_s1;
            r_s_prev <= r_s2;
            r_state <= w_next;
            r_cnt <= w_cnt;
            r_idx <= w_idx;
            r_data <= w_data;
            r_par <= w_par;
            r_upcm <= w_load ? r_data : r_upcm;
            r_valid <= w_load;
            r_err <= w_err;
            r_have <= r_have | w_load;
        end
    end
    assign bus.U = r_upcm[3];
    assign bus.P = r_upcm[2];
    assign bus.C = r_upcm[1];
    assign bus.M = r_upcm[0];
    assign bus.code_valid = r_valid;
    assign bus.frame_err = r_err;
    assign bus.have_code = r_have;
endmodule

// File: tb/tb_upc_scan_receiver.sv
// tb_upc_scan_receiver: directed frames against a sample-schedule model of the receiver, plus literal checks.
module tb_upc_scan_receiver;
    localparam int BC = 4;
    localparam bit PODD = 1'b1;
    logic clk;
    logic reset;
    int cyc = 0;
    int vecs = 0;
    int errs = 0;
    int fall_cyc = 0;
    int n_cv = 0;
    int n_fe = 0;
    int last_cv = 0;
    int prev_cv = 0;
    upc_scan_receiver_if bus ();
    upc_scan_receiver #(.BIT_CYCLES(BC), .PARITY_ODD(PODD)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Model: the line seen by the receiver is scan_in two cycles late (ones after reset).
    // After a falling edge, sample k (k=0 start, 1..4 U,P,C,M, 5 parity, 6 stop) is taken
    // BC/2 + k*BC cycles later; the verdict appears on the outputs the cycle after the stop sample.
    logic [1:0] m_q;
    logic m_prev, m_s, m_ok;
    logic [6:1] m_bits;
    logic [3:0] m_upcm;
    logic m_cv, m_fe, m_have;
    int m_age, m_k, m_code;
    initial m_ok = 1'b0;
    always @(posedge clk) begin
        m_cv = 1'b0;
        m_fe = 1'b0;
        if (reset) begin
            m_q = 2'b11;
            m_prev = 1'b1;
            m_age = -1;
            m_upcm = 4'b0000;
            m_have = 1'b0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            m_s = m_q[1];
            if (m_age < 0) begin
                if (!m_s && m_prev) m_age = 0;
            end else begin
                m_age = m_age + 1;
                if (m_age >= BC / 2 && (m_age - BC / 2) % BC == 0) begin
                    m_k = (m_age - BC / 2) / BC;
                    if (m_k == 0) begin
                        if (m_s) m_age = -1;
                    end else if (m_k < 6) begin
                        m_bits[m_k] = m_s;
                    end else begin
                        m_code = 4 * m_bits[1] + 2 * m_bits[2] + m_bits[3];
                        if (m_s && ((m_bits[1] ^ m_bits[2] ^ m_bits[3] ^ m_bits[4] ^ m_bits[5]) == PODD)
                            && m_code != 2 && m_code != 7) begin
                            m_upcm = {m_bits[1], m_bits[2], m_bits[3], m_bits[4]};
                            m_cv = 1'b1;
                            m_have = 1'b1;
                        end else begin
                            m_fe = 1'b1;
                        end
                        m_age = -1;
                    end
                end
            end
            m_prev = m_s;
            m_q = {m_q[0], bus.scan_in};
        end
    end
    logic [6:0] got_o, want_o;
    assign got_o = {bus.U, bus.P, bus.C, bus.M, bus.code_valid, bus.frame_err, bus.have_code};
    assign want_o = {m_upcm, m_cv, m_fe, m_have};
    task automatic lit(input string nm, input int got, input int want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask
    task automatic hold(input logic b, input int n);
        bus.scan_in = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    // f = {U,P,C,M,parity,stop}
    task automatic send(input logic [5:0] f);
        fall_cyc = cyc;
        hold(1'b0, BC);
        for (int i = 5; i >= 0; i--) hold(f[i], BC);
    endtask
    initial begin
        fork
            forever begin
                @(negedge clk);
                if (m_ok) begin
                    vecs++;
                    if (got_o !== want_o) begin
                        errs++;
                        $display("FAIL outputs cyc %0d: got UPCM,cv,fe,have=%b want %b", cyc, got_o, want_o);
                    end
                    if (bus.code_valid) begin
                        n_cv++;
                        prev_cv = last_cv;
                        last_cv = cyc;
                    end
                    if (bus.frame_err) n_fe++;
                end
            end
        join_none
        reset = 1'b1;
        bus.scan_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        lit("reset_outputs", int'(got_o), 0);
        hold(1'b1, 4);
        send(6'b101011);
        hold(1'b1, 8);
        // two synchronizer cycles, then the start edge, BC/2 + 6*BC sampling cycles and the output register
        lit("first_latency", last_cv - fall_cyc, BC / 2 + 6 * BC + 1 + 2);
        lit("first_upcm", int'(got_o[6:3]), 4'b1010);
        lit("first_have", int'(bus.have_code), 1);
        lit("first_cv_count", n_cv, 1);
        send(6'b110111);
        hold(1'b1, 8);
        lit("badpar_fe_count", n_fe, 1);
        lit("badpar_upcm", int'(got_o[6:3]), 4'b1010);
        send(6'b111001);
        hold(1'b1, 8);
        lit("code111_fe_count", n_fe, 2);
        send(6'b010001);
        hold(1'b1, 8);
        lit("code010_fe_count", n_fe, 3);
        lit("illegal_cv_count", n_cv, 1);
        lit("illegal_upcm", int'(got_o[6:3]), 4'b1010);
        hold(1'b0, 1);
        hold(1'b1, 8);
        lit("glitch_pulses", n_cv + n_fe, 4);
        send(6'b011101);
        hold(1'b1, 8);
        lit("after_glitch_upcm", int'(got_o[6:3]), 4'b0111);
        lit("after_glitch_cv_count", n_cv, 2);
        hold(1'b0, BC);
        hold(1'b1, BC + 2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lit("midframe_reset_outputs", int'(got_o), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        hold(1'b1, 22);
        lit("aborted_pulses", n_cv + n_fe, 5);
        send(6'b100001);
        hold(1'b1, 8);
        lit("post_reset_upcm", int'(got_o[6:3]), 4'b1000);
        lit("post_reset_have", int'(bus.have_code), 1);
        send(6'b100000);
        hold(1'b0, 3 * BC);
        hold(1'b1, 8);
        lit("stop0_fe_count", n_fe, 4);
        lit("stop0_cv_count", n_cv, 3);
        send(6'b110011);
        send(6'b001001);
        hold(1'b1, 8);
        lit("b2b_cv_count", n_cv, 5);
        lit("b2b_gap", last_cv - prev_cv, 7 * BC);
        lit("b2b_upcm", int'(got_o[6:3]), 4'b0010);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
